// File: rtl/instr_pair_encoder_if.sv
// Handshake bundle for instr_pair_encoder: field-record input side, pair output side and status.
// The producer/consumer side uses the master modport and the encoder uses the slave modport.
interface instr_pair_encoder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_op;
    logic [4:0]            in_rd;
    logic [2:0]            in_funct3;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [6:0]            in_funct7;
    logic [11:0]           in_imm12;
    logic [19:0]           in_imm20;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr_a;
    logic [31:0]           out_instr_b;
    logic                  out_b_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  idle;
    logic [7:0]            err_count;

    modport master (
        output in_valid, in_op, in_rd, in_funct3, in_rs1, in_rs2, in_funct7,
               in_imm12, in_imm20, flush, out_ready,
        input  in_ready, out_valid, out_instr_a, out_instr_b, out_b_valid,
               out_addr, idle, err_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_funct3, in_rs1, in_rs2, in_funct7,
               in_imm12, in_imm20, flush, out_ready,
        output in_ready, out_valid, out_instr_a, out_instr_b, out_b_valid,
               out_addr, idle, err_count
    );
endinterface

// File: rtl/instr_pair_encoder.sv
// Re-encodes decoded RV32 field records into 32-bit words, packs them into A/B issue pairs
// and queues the pairs with addresses. Optional macro ENC_ILLEGAL_OP_DROP_EN drops unknown ops.
module instr_pair_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic clk,
    input  logic reset,
    instr_pair_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [31:0]           NOP_WORD   = 32'h00000013;
    localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(8);
    localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FIFO_DEPTH);

    logic [31:0]           fifo_a    [FIFO_DEPTH];
    logic [31:0]           fifo_b    [FIFO_DEPTH];
    logic                  fifo_bv   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  hold_valid;
    logic [31:0]           hold_word;
    logic                  flush_pend;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [7:0]            err_cnt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  pop;
    logic                  pack_word;
    logic [31:0]           enc_word;
    logic                  push;
    logic [31:0]           push_a;
    logic [31:0]           push_b;
    logic                  push_bv;
    logic                  hold_valid_nxt;
    logic [31:0]           hold_word_nxt;
    logic                  flush_pend_nxt;

    // Unknown opcodes fall through to the R layout.
    function automatic logic [31:0] encode_fields(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [2:0]  funct3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [6:0]  funct7,
        input logic [11:0] imm12,
        input logic [19:0] imm20
    );
        logic [31:0] word;
        case (op)
            OP_LOAD, OP_IMM: word = {imm12, rs1, funct3, rd, op};
            OP_STORE:        word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], op};
            OP_BR:           word = {imm12[11], imm12[9:4], rs2, rs1, funct3,
                                     imm12[3:0], imm12[10], op};
            OP_JAL:          word = {imm20[19], imm20[10:0], imm20[11], imm20[18:12], rd, op};
            default:         word = {funct7, rs2, rs1, funct3, rd, op};
        endcase
        return word;
    endfunction

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // in_ready looks only at registered state so out_ready never reaches it combinationally.
    assign bus.in_ready = !flush_pend && (!hold_valid || !fifo_full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = !fifo_empty && bus.out_ready;

    assign enc_word = encode_fields(bus.in_op, bus.in_rd, bus.in_funct3, bus.in_rs1,
                                    bus.in_rs2, bus.in_funct7, bus.in_imm12, bus.in_imm20);

`ifdef ENC_ILLEGAL_OP_DROP_EN
    function automatic logic op_is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_IMM) ||
               (op == OP_STORE) || (op == OP_BR) || (op == OP_JAL);
    endfunction

    assign pack_word = op_is_legal(bus.in_op);

    // Dropped records are still consumed; the counter sticks at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (accept && !pack_word && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign pack_word = 1'b1;
    assign err_cnt   = '0;
`endif

    // The accepted word is packed first; a pending flush then sees the post-accept holder.
    always_comb begin
        hold_valid_nxt = hold_valid;
        hold_word_nxt  = hold_word;
        flush_pend_nxt = flush_pend || bus.flush;
        push           = 1'b0;
        push_a         = '0;
        push_b         = '0;
        push_bv        = 1'b0;

        if (accept && pack_word) begin
            if (!hold_valid) begin
                hold_valid_nxt = 1'b1;
                hold_word_nxt  = enc_word;
            end else begin
                push           = 1'b1;
                push_a         = hold_word;
                push_b         = enc_word;
                push_bv        = 1'b1;
                hold_valid_nxt = 1'b0;
            end
        end

        if (flush_pend_nxt) begin
            if (!hold_valid_nxt) begin
                flush_pend_nxt = 1'b0;
            end else if (!fifo_full) begin
                push           = 1'b1;
                push_a         = hold_word_nxt;
                push_b         = NOP_WORD;
                push_bv        = 1'b0;
                hold_valid_nxt = 1'b0;
                flush_pend_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
            flush_pend <= 1'b0;
            addr_cnt   <= ADDR_START;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            hold_valid <= hold_valid_nxt;
            hold_word  <= hold_word_nxt;
            flush_pend <= flush_pend_nxt;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                addr_cnt <= addr_cnt + ADDR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]    <= push_a;
            fifo_b[wr_ptr]    <= push_b;
            fifo_bv[wr_ptr]   <= push_bv;
            fifo_addr[wr_ptr] <= addr_cnt;
        end
    end

    assign bus.out_valid   = !fifo_empty;
    assign bus.out_instr_a = fifo_empty ? 32'h0 : fifo_a[rd_ptr];
    assign bus.out_instr_b = fifo_empty ? 32'h0 : fifo_b[rd_ptr];
    assign bus.out_b_valid = fifo_empty ? 1'b0 : fifo_bv[rd_ptr];
    assign bus.out_addr    = fifo_empty ? ADDR_START : fifo_addr[rd_ptr];
    assign bus.idle        = !hold_valid && fifo_empty && !flush_pend;
    assign bus.err_count   = err_cnt;
endmodule

// File: tb/tb_instr_pair_encoder.sv
// Directed bench for instr_pair_encoder: pairing, flush, backpressure, address wrap,
// illegal-op handling, mid-stream reset and a decode/encode round trip.
`timescale 1ns/1ps
module tb_instr_pair_encoder;
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [11:0] imm12;
        logic [19:0] imm20;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        qbv[$];
    logic [9:0]  qaddr[$];
    logic [3:0]  wrap_addr[$];

    always #5 clk = ~clk;

    instr_pair_encoder_if #(.ADDR_WIDTH(10)) bus ();
    instr_pair_encoder_if #(.ADDR_WIDTH(4))  busw ();

    instr_pair_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    instr_pair_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut_wrap (
        .clk(clk), .reset(reset), .bus(busw)
    );

    // The narrow-address copy sees exactly the same stream as the main instance.
    assign busw.in_valid  = bus.in_valid;
    assign busw.in_op     = bus.in_op;
    assign busw.in_rd     = bus.in_rd;
    assign busw.in_funct3 = bus.in_funct3;
    assign busw.in_rs1    = bus.in_rs1;
    assign busw.in_rs2    = bus.in_rs2;
    assign busw.in_funct7 = bus.in_funct7;
    assign busw.in_imm12  = bus.in_imm12;
    assign busw.in_imm20  = bus.in_imm20;
    assign busw.flush     = bus.flush;
    assign busw.out_ready = bus.out_ready;

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            qa.push_back(bus.out_instr_a);
            qb.push_back(bus.out_instr_b);
            qbv.push_back(bus.out_b_valid);
            qaddr.push_back(bus.out_addr);
        end
        if (!reset && busw.out_valid && busw.out_ready) begin
            wrap_addr.push_back(busw.out_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic rec_t mk_rec(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                    input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                                    input logic [11:0] imm12, input logic [19:0] imm20);
        rec_t r;
        r.op = op; r.rd = rd; r.f3 = f3; r.rs1 = rs1; r.rs2 = rs2;
        r.f7 = f7; r.imm12 = imm12; r.imm20 = imm20;
        return r;
    endfunction

    // Reference decoder: splits a word back into field records.
    function automatic rec_t decode_word(input logic [31:0] w);
        rec_t r;
        r.op = w[6:0]; r.rd = w[11:7]; r.f3 = w[14:12];
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.f7 = w[31:25];
        case (w[6:0])
            7'b0000011, 7'b0010011: r.imm12 = w[31:20];
            7'b0100011:             r.imm12 = {w[31:25], w[11:7]};
            7'b1100011:             r.imm12 = {w[31], w[7], w[30:25], w[11:8]};
            default:                r.imm12 = 12'h0;
        endcase
        r.imm20 = {w[31], w[18:12], w[19], w[30:20]};
        return r;
    endfunction

    function automatic logic [31:0] gen_random_instr();
        logic [6:0] ops [6];
        ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0010011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        return {$urandom() & 32'hFFFF_FF80} | {25'h0, ops[$urandom_range(5, 0)]};
    endfunction

    task automatic drive_rec(input rec_t r);
        bus.in_op = r.op; bus.in_rd = r.rd; bus.in_funct3 = r.f3;
        bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2; bus.in_funct7 = r.f7;
        bus.in_imm12 = r.imm12; bus.in_imm20 = r.imm20;
    endtask

    task automatic applyStimulus(input rec_t r);
        int n;
        n = 0;
        drive_rec(r);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            stalls++;
        end
        if (n >= 200) checkOutput("in_ready_wait", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic checkPair(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic ebv, input logic [9:0] eaddr);
        int n;
        n = 0;
        while (qa.size() == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput($sformatf("%s_present", tag), 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) begin
            checkOutput($sformatf("%s_a", tag), 64'(qa.pop_front()), 64'(ea));
            checkOutput($sformatf("%s_b", tag), 64'(qb.pop_front()), 64'(eb));
            checkOutput($sformatf("%s_bv", tag), 64'(qbv.pop_front()), 64'(ebv));
            checkOutput($sformatf("%s_addr", tag), 64'(qaddr.pop_front()), 64'(eaddr));
        end
    endtask

    initial begin
        rec_t r1, r2, r3, r4, r5, r6, r7, r8, r9, rill;
        logic [31:0] bp_words [9];
        logic [31:0] rt_words [$];
        logic [31:0] w;
        int accepted;
        int n;

        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_rec('0);

        r1 = mk_rec(7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'h00, 12'hFFF, 20'hABCDE);
        r2 = mk_rec(7'b0110011, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20, 12'h123, 20'h0);
        r3 = mk_rec(7'b0110011, 5'd8, 3'd4, 5'd9, 5'd10, 7'h00, 12'h0, 20'h0);
        r4 = mk_rec(7'b0110011, 5'd11, 3'd6, 5'd12, 5'd13, 7'h00, 12'h0, 20'h0);
        r5 = mk_rec(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd31, 7'h7F, 12'h005, 20'h0);
        r6 = mk_rec(7'b0100011, 5'd0, 3'd2, 5'd3, 5'd2, 7'h00, 12'h7E5, 20'h0);
        r7 = mk_rec(7'b1100011, 5'd0, 3'd1, 5'd5, 5'd4, 7'h00, 12'hA5B, 20'h0);
        r8 = mk_rec(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 12'h0, 20'hC3A5F);
        r9 = mk_rec(7'b0000011, 5'd6, 3'd2, 5'd7, 5'd0, 7'h00, 12'hFFC, 20'h0);
        rill = mk_rec(7'h7F, 5'd3, 3'd0, 5'd1, 5'd2, 7'h01, 12'h0, 20'h0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_idle", 64'(bus.idle), 64'd1);
        checkOutput("rst_err", 64'(bus.err_count), 64'd0);
        checkOutput("rst_b_valid", 64'(bus.out_b_valid), 64'd0);
        checkOutput("rst_instr_a", 64'(bus.out_instr_a), 64'd0);
        checkOutput("rst_instr_b", 64'(bus.out_instr_b), 64'd0);
        checkOutput("rst_addr", 64'(bus.out_addr), 64'd0);

        // Pairing, one-cycle latency and addresses.
        bus.out_ready = 1'b1;
        applyStimulus(r1);
        applyStimulus(r2);
        checkOutput("lat_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("lat_instr_a", 64'(bus.out_instr_a), 64'h003100B3);
        applyStimulus(r3);
        applyStimulus(r4);
        checkPair("pair0", 32'h003100B3, 32'h407302B3, 1'b1, 10'd0);
        checkPair("pair1", 32'h00A4C433, 32'h00D665B3, 1'b1, 10'd8);

        // I/S/B words, then a flush that emits the odd B word with a NOP partner.
        applyStimulus(r5);
        applyStimulus(r6);
        applyStimulus(r7);
        checkOutput("flush_pre_idle", 64'(bus.idle), 64'd0);
        pulse_flush();
        checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("flush_instr_a", 64'(bus.out_instr_a), 64'hCA429B63);
        checkOutput("flush_instr_b", 64'(bus.out_instr_b), 64'(NOP_WORD));
        checkOutput("flush_b_valid", 64'(bus.out_b_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_idle_after", 64'(bus.idle), 64'd1);
        checkPair("pair2", 32'h00500093, 32'h7E21A2A3, 1'b1, 10'd16);
        checkPair("pair3", 32'hCA429B63, NOP_WORD, 1'b0, 10'd24);

        checkOutput("wrap_cnt", 64'(wrap_addr.size() >= 3), 64'd1);
        if (wrap_addr.size() >= 3) begin
            checkOutput("wrap_addr0", 64'(wrap_addr[0]), 64'd0);
            checkOutput("wrap_addr1", 64'(wrap_addr[1]), 64'd8);
            checkOutput("wrap_addr2", 64'(wrap_addr[2]), 64'd0);
        end

        applyStimulus(r8);
        applyStimulus(r9);
        checkPair("pair_jal", 32'hA5FC30EF, 32'hFFC3A303, 1'b1, 10'd32);

        // Backpressure: four pairs fill the FIFO, a ninth word waits in the holder.
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            if (!bus.in_ready) break;
            w = gen_random_instr();
            bp_words[accepted] = w;
            drive_rec(decode_word(w));
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            accepted++;
            if (accepted == 9) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        checkOutput("bp_accepts", 64'(accepted), 64'd9);
        checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_a", 64'(bus.out_instr_a), 64'(bp_words[0]));
        checkOutput("bp_hold_addr", 64'(bus.out_addr), 64'd40);
        bus.out_ready = 1'b1;
        pulse_flush();
        if (accepted == 9) begin
            for (int p = 0; p < 4; p++) begin
                checkPair($sformatf("bp_pair%0d", p), bp_words[2*p], bp_words[2*p+1], 1'b1,
                          10'(40 + 8*p));
            end
            checkPair("bp_pair4", bp_words[8], NOP_WORD, 1'b0, 10'd72);
        end

        // Unknown opcode followed by two R words.
        applyStimulus(rill);
        applyStimulus(r1);
        applyStimulus(r2);
`ifdef ENC_ILLEGAL_OP_DROP_EN
        checkPair("ill_pair", 32'h003100B3, 32'h407302B3, 1'b1, 10'd80);
        checkOutput("ill_err", 64'(bus.err_count), 64'd1);
`else
        checkPair("ill_pair", 32'h022081FF, 32'h003100B3, 1'b1, 10'd80);
        checkOutput("ill_err", 64'(bus.err_count), 64'd0);
        pulse_flush();
        checkPair("ill_tail", 32'h407302B3, NOP_WORD, 1'b0, 10'd88);
`endif

        // Reset in the middle of a stream with a pair queued and a word held.
        bus.out_ready = 1'b0;
        applyStimulus(r3);
        applyStimulus(r4);
        applyStimulus(rill);
        checkOutput("mid_out_valid_pre", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_err", 64'(bus.err_count), 64'd0);
        checkOutput("mid_idle", 64'(bus.idle), 64'd1);
        checkOutput("mid_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_addr", 64'(bus.out_addr), 64'd0);

        // Round trip of random legal words at one record per cycle.
        qa.delete(); qb.delete(); qbv.delete(); qaddr.delete();
        bus.out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            w = gen_random_instr();
            rt_words.push_back(w);
            applyStimulus(decode_word(w));
        end
        checkOutput("rt_no_stall", 64'(stalls), 64'd0);
        n = 0;
        while (qa.size() < 100 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rt_pair_count", 64'(qa.size()), 64'd100);
        for (int p = 0; p < 100; p++) begin
            checkPair($sformatf("rt%0d", p), rt_words[2*p], rt_words[2*p+1], 1'b1, 10'(8*p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
